s_rca_pipe: RTL and testbench
=============================

Name: s_rca_pipe

Overview:
- Parametrised, pipelined successor to the flat signed ripple-carry adder: WIDTH-bit add/subtract split into STAGES ripple-carry chunks, with the carry registered between chunks.
- Produces a WIDTH+1-bit result. In signed mode the top bit is a true sign extension; in unsigned mode it is the carry-out.
- Valid/ready streaming interface with backpressure and a per-transaction add/sub mode.
- Sits in arithmetic datapaths that need full throughput at clock rates a flat 16/32/64-bit ripple adder cannot meet.

Parameters:
- WIDTH, 16, operand width; must be a multiple of STAGES.
- STAGES, 4, pipeline ranks; chunk width C = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.
- SIGNED, 1, 1 = two's-complement result extension; 0 = unsigned, top bit is carry-out.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = a+b, 1 = a-b
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out  out  WIDTH+1  result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; no synchronous reset.
- Reset values: all rank valid bits 0, so out_valid=0. out, out_tag and all data registers are 0. in_ready=1 while in reset.
- Global stall: advance = !out_valid || out_ready. When advance=0, every rank holds.
- in_ready = advance, and is combinational from out_valid/out_ready.
- Acceptance happens on an edge with in_valid && in_ready.
- Operand conditioning: b_eff = sub ? ~b : b; carry-in c0 = sub.
- Rank 0 computes chunk 0 combinationally from the inputs.
  - It registers sum bits [C-1:0], carry c1, the not-yet-used operand bits, the sign inputs a[WIDTH-1] and b_eff[WIDTH-1], the tag and valid.
- Rank k (k ≥ 1) computes chunk k from rank k-1's skewed operands and registered carry.
  - It appends sum bits [k*C+C-1 : k*C] to the already-completed low sum bits.
- Top bit, formed in the final rank:
  - SIGNED=1: out[WIDTH] = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ c_WIDTH.
  - SIGNED=0: out[WIDTH] = c_WIDTH.
- Latency: exactly STAGES cycles from the acceptance edge to out_valid, absent stalls. Throughput is one operation per cycle.
- Bubbles propagate as valid=0 ranks and are not collapsed. Data in invalid ranks is don't-care but must not reach out when out_valid=0; out holds its last value.
- Simultaneous events:
  - With out_valid && out_ready && in_valid on the same edge, output retire and input accept both occur.
  - A full pipeline sustains 100% throughput.
- Stall: out, out_tag and out_valid stay stable while out_valid && !out_ready (standard valid/ready rule).
- Reset mid-operation discards all in-flight operations. out_valid drops asynchronously and no partial result is ever presented.
- STAGES=1 degenerates to a registered full-width ripple adder.

Optional Feature:
- Macro S_RCA_PIPE_OVF_EN.
- Defined: adds output port ovf (1 bit), aligned with out and reset to 0.
  - SIGNED=1: ovf = c_WIDTH ^ c_(WIDTH-1), i.e. the result does not fit in WIDTH bits.
  - SIGNED=0: ovf = c_WIDTH ^ sub, i.e. unsigned carry-out on add, borrow on sub.
- Undefined: no ovf port and no extra logic; behaviour is otherwise identical.

Decomposition:
- Package s_rca_pipe_pkg:
  - chunk-width function chunk_w(WIDTH, STAGES);
  - elaboration check that WIDTH % STAGES == 0;
  - typedef for the rank payload struct (sum, carry, skewed operands, sign bits, tag, valid).
- One sub-module, rca_chunk: C-bit combinational ripple chain of half/full-adder cells (a, b, cin → s, cout, and c_(msb) for the overflow tap). Instantiated STAGES times inside a generate loop.

Test Plan (WIDTH=16, STAGES=4, SIGNED=1):
- Signed add with overflow: a=0x7FFF, b=0x0001, sub=0, tag=3 → 4 cycles later out=17'h08000, out_tag=3; ovf=1 when S_RCA_PIPE_OVF_EN is defined.
- Signed sub: a=0x8000, b=0x0001, sub=1 → out=17'h17FFF (−32769); ovf=1.
- Negative add: a=0xFFFF, b=0xFFFF → out=17'h1FFFE (−2), ovf=0. With SIGNED=0, the same stimulus → out=17'h1FFFE, ovf=1.
- Back-to-back: 20 random operations with in_valid held high and out_ready=1 → in_ready never drops; results match a reference model in order with matching tags; 1 op/cycle.
- Backpressure: out_ready=0 for 6 cycles with the pipe full → in_ready=0; out/out_tag stable; no loss or duplication after release.
- Reset mid-op: assert rst_n=0 with 3 ops in flight → out_valid=0 immediately; after release, the first new op (0x1234+0x0001) → out=17'h01235 after exactly 4 cycles.

Source files
------------

// File: rtl/s_rca_pipe_pkg.sv
// -----------------------------------------------------------------------------
// s_rca_pipe_pkg
// Shared helpers for the pipelined ripple-carry adder s_rca_pipe.
//   chunk_w : width of one ripple chunk (one pipeline rank)
//   cfg_ok  : legality of a WIDTH/STAGES pair. The top evaluates it at
//             elaboration, so an odd split fails the build.
// The rank payload struct lives in the top module. Its field widths depend on
// the instance parameters, and a package cannot see them.
// -----------------------------------------------------------------------------
package s_rca_pipe_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// -----------------------------------------------------------------------------
// rca_chunk
// C-bit combinational ripple chain of full-adder cells.
//   a, b   : chunk operands
//   cin    : carry into bit 0
//   s      : chunk sum
//   cout   : carry out of the msb
//   c_msb  : carry into the msb (overflow tap); present only when
//            S_RCA_PIPE_OVF_EN is defined
// -----------------------------------------------------------------------------
module rca_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] s,
  output logic         cout
`ifdef S_RCA_PIPE_OVF_EN
  ,
  output logic         c_msb
`endif
);

  // c[i] is the carry into bit i; c[C] is the chunk carry-out.
  logic [C:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < C; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[C];

`ifdef S_RCA_PIPE_OVF_EN
  assign c_msb = c[C-1];
`endif

endmodule

// File: rtl/s_rca_pipe.sv
// -----------------------------------------------------------------------------
// s_rca_pipe
// Pipelined WIDTH-bit add/subtract. The ripple chain is cut into STAGES chunks
// of C = WIDTH/STAGES bits, and a carry register sits between each chunk.
// The result is WIDTH+1 bits wide. When SIGNED=1 the top bit is a sign
// extension. When SIGNED=0 the top bit is the carry-out.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, sub, in_tag)
//   sub                 : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake (out, out_tag)
//   ovf                 : overflow, aligned with out. This port exists only
//                         when the macro S_RCA_PIPE_OVF_EN is defined.
//
// Handshake: a transfer occurs on a rising edge where valid && ready.
// The whole pipe advances only when the output slot is empty or being drained:
// advance = !out_valid || out_ready. in_ready equals advance, so it is a
// combinational function of out_valid and out_ready only. out, out_tag and
// out_valid are held while out_valid && !out_ready.
// -----------------------------------------------------------------------------
module s_rca_pipe
  import s_rca_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int SIGNED = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic [TAG_W-1:0] out_tag
`ifdef S_RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int C = chunk_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("s_rca_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // One pipeline rank. The full operands travel with the op. Each rank
  // consumes only its own chunk, and synthesis trims the bits already used.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sum;    // low chunks completed so far
    logic             carry;  // carry into the next chunk
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;      // already conditioned (b_eff)
    logic             sa;     // a[WIDTH-1]
    logic             sb;     // b_eff[WIDTH-1]
`ifdef S_RCA_PIPE_OVF_EN
    logic             sub;
    logic             c_msb;  // carry into bit WIDTH-1 (valid in last rank)
`endif
  } rank_t;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             top_bit;
  rank_t            in_src;
  rank_t            pipe [STAGES];
  rank_t            nxt  [STAGES];

  logic [C-1:0] ch_a  [STAGES];
  logic [C-1:0] ch_b  [STAGES];
  logic [C-1:0] ch_s  [STAGES];
  logic         ch_ci [STAGES];
  logic         ch_co [STAGES];
`ifdef S_RCA_PIPE_OVF_EN
  logic         ch_cm [STAGES];
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1. The +1 enters as the chunk-0 carry-in.
  assign b_eff = sub ? ~b : b;

  always_comb begin
    in_src       = '0;
    in_src.valid = in_valid;
    in_src.tag   = in_tag;
    in_src.a     = a;
    in_src.b     = b_eff;
    in_src.carry = sub;
    in_src.sa    = a[WIDTH-1];
    in_src.sb    = b_eff[WIDTH-1];
`ifdef S_RCA_PIPE_OVF_EN
    in_src.sub   = sub;
`endif
  end

  // Chunk k adds bits [k*C +: C]. Chunk 0 is fed from the ports. Later chunks
  // are fed from the previous rank's registered operands and carry.
  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    if (k == 0) begin : g_first
      assign ch_a[k]  = in_src.a[C-1:0];
      assign ch_b[k]  = in_src.b[C-1:0];
      assign ch_ci[k] = in_src.carry;
    end else begin : g_next
      assign ch_a[k]  = pipe[k-1].a[k*C +: C];
      assign ch_b[k]  = pipe[k-1].b[k*C +: C];
      assign ch_ci[k] = pipe[k-1].carry;
    end

    rca_chunk #(.C(C)) u_chunk (
      .a    (ch_a[k]),
      .b    (ch_b[k]),
      .cin  (ch_ci[k]),
      .s    (ch_s[k]),
      .cout (ch_co[k])
`ifdef S_RCA_PIPE_OVF_EN
      ,
      .c_msb(ch_cm[k])
`endif
    );
  end

  always_comb begin
    nxt[0]              = in_src;
    nxt[0].sum[C-1:0]   = ch_s[0];
    nxt[0].carry        = ch_co[0];
`ifdef S_RCA_PIPE_OVF_EN
    nxt[0].c_msb        = ch_cm[0];
`endif
    for (int k = 1; k < STAGES; k++) begin
      nxt[k]              = pipe[k-1];
      nxt[k].sum[k*C +: C] = ch_s[k];
      nxt[k].carry        = ch_co[k];
`ifdef S_RCA_PIPE_OVF_EN
      nxt[k].c_msb        = ch_cm[k];
`endif
    end
  end

  // A bubble only clears the valid bit. The payload is left as it was, so the
  // last rank (and therefore out) keeps its final valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (nxt[k].valid) pipe[k] <= nxt[k];
        else              pipe[k].valid <= 1'b0;
      end
    end
  end

  // The top bit comes from registered fields of the last rank, so it is
  // aligned with out and reads 0 out of reset.
  assign top_bit   = (SIGNED != 0)
                   ? (pipe[STAGES-1].sa ^ pipe[STAGES-1].sb ^ pipe[STAGES-1].carry)
                   : pipe[STAGES-1].carry;
  assign out_valid = pipe[STAGES-1].valid;
  assign out_tag   = pipe[STAGES-1].tag;
  assign out       = {top_bit, pipe[STAGES-1].sum};

`ifdef S_RCA_PIPE_OVF_EN
  // Signed: carries into and out of the msb disagree.
  // Unsigned: carry-out on add, or borrow (no carry-out) on subtract.
  assign ovf = (SIGNED != 0)
             ? (pipe[STAGES-1].carry ^ pipe[STAGES-1].c_msb)
             : (pipe[STAGES-1].carry ^ pipe[STAGES-1].sub);
`endif

endmodule

// File: tb/tb_s_rca_pipe.sv
// -----------------------------------------------------------------------------
// tb_s_rca_pipe
// Directed and scoreboarded checks of s_rca_pipe (WIDTH=16, STAGES=4).
// A signed instance (u_dut) and an unsigned instance (u_dut_u) share the same
// stimulus. Define S_RCA_PIPE_OVF_EN to also check the ovf outputs.
// -----------------------------------------------------------------------------
module tb_s_rca_pipe;

  localparam int STAGES = 4;
  localparam int EW     = 40;  // {tag, ovf_u, ovf, out_u, out}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  in_tag = '0;

  logic        in_ready, out_valid, in_ready_u, out_valid_u;
  logic [16:0] out, out_u;
  logic [3:0]  out_tag, out_tag_u;
`ifdef S_RCA_PIPE_OVF_EN
  logic        ovf, ovf_u;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  s_rca_pipe #(.WIDTH(16), .STAGES(STAGES), .SIGNED(1), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag)
`ifdef S_RCA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  s_rca_pipe #(.WIDTH(16), .STAGES(STAGES), .SIGNED(0), .TAG_W(4)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid_u), .out_ready(out_ready), .out(out_u), .out_tag(out_tag_u)
`ifdef S_RCA_PIPE_OVF_EN
    , .ovf(ovf_u)
`endif
  );

  // Reference: plain integer arithmetic, signed and unsigned.
  function automatic logic [EW-1:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic ms, input logic [3:0] mt);
    logic signed [16:0] sa, sb, r;
    logic [16:0] ru;
    logic ov, ovu;
    sa = {ma[15], ma};
    sb = {mb[15], mb};
    r  = ms ? (sa - sb) : (sa + sb);
    ov = (r[16] != r[15]);
    if (!ms) begin
      ru  = {1'b0, ma} + {1'b0, mb};
      ovu = ru[16];
    end else begin
      ru[15:0] = ma - mb;
      ru[16]   = (ma >= mb);
      ovu      = (ma < mb);
    end
    return {mt, ovu, ov, ru, r};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out !== 17'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out); end
    n_checks++; if (out_tag !== 4'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (in_ready_u !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_u: got %b expected 1", in_ready_u); end
    n_checks++; if (out_u !== 17'h0) begin n_fail++; $display("FAIL reset_out_u: got %h expected 0", out_u); end
`ifdef S_RCA_PIPE_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [4]  = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    logic [15:0] vb [4]  = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0002};
    logic        vs [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  vt [4]  = '{4'd3, 4'd5, 4'd9, 4'd12};
    logic [16:0] ve [4]  = '{17'h08000, 17'h17FFF, 17'h1FFFE, 17'h1FFFF};
    logic [16:0] veu[4]  = '{17'h08000, 17'h17FFF, 17'h1FFFE, 17'h0FFFF};
`ifdef S_RCA_PIPE_OVF_EN
    logic        vo [4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        vou[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; sub = vs[i]; in_tag = vt[i]; in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
      for (int c = 1; c <= STAGES; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== (c == STAGES)) begin
          n_fail++; $display("FAIL dir%0d_latency_c%0d: got out_valid %b expected %b", i, c, out_valid, (c == STAGES));
        end
      end
      n_checks++; if (out !== ve[i]) begin n_fail++; $display("FAIL dir%0d_out: got %h expected %h", i, out, ve[i]); end
      n_checks++; if (out_tag !== vt[i]) begin n_fail++; $display("FAIL dir%0d_tag: got %h expected %h", i, out_tag, vt[i]); end
      n_checks++; if (out_u !== veu[i]) begin n_fail++; $display("FAIL dir%0d_out_u: got %h expected %h", i, out_u, veu[i]); end
      n_checks++; if (out_tag_u !== vt[i]) begin n_fail++; $display("FAIL dir%0d_tag_u: got %h expected %h", i, out_tag_u, vt[i]); end
`ifdef S_RCA_PIPE_OVF_EN
      n_checks++; if (ovf !== vo[i]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b expected %b", i, ovf, vo[i]); end
      n_checks++; if (ovf_u !== vou[i]) begin n_fail++; $display("FAIL dir%0d_ovf_u: got %b expected %b", i, ovf_u, vou[i]); end
`endif
      @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_drop: got out_valid %b expected 0", i, out_valid); end
      n_checks++; if (out !== ve[i]) begin n_fail++; $display("FAIL dir%0d_hold: got %h expected %h", i, out, ve[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int got = 0, sent = 0, first = -1, last = -1;
    logic [EW-1:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_unexpected: got out %h expected no output", out);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (out !== e[16:0]) begin n_fail++; $display("FAIL b2b_out%0d: got %h expected %h", got, out, e[16:0]); end
          n_checks++; if (out_u !== e[33:17]) begin n_fail++; $display("FAIL b2b_out_u%0d: got %h expected %h", got, out_u, e[33:17]); end
          n_checks++; if (out_tag !== e[39:36]) begin n_fail++; $display("FAIL b2b_tag%0d: got %h expected %h", got, out_tag, e[39:36]); end
`ifdef S_RCA_PIPE_OVF_EN
          n_checks++; if (ovf !== e[34]) begin n_fail++; $display("FAIL b2b_ovf%0d: got %b expected %b", got, ovf, e[34]); end
          n_checks++; if (ovf_u !== e[35]) begin n_fail++; $display("FAIL b2b_ovf_u%0d: got %b expected %b", got, ovf_u, e[35]); end
`endif
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (sent < 20) begin
        a = 16'($urandom_range(0, 65535));
        b = 16'($urandom_range(0, 65535));
        sub = 1'($urandom_range(0, 1));
        in_tag = 4'(sent);
        in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b expected 1", sent, in_ready); end
        exp_q.push_back(model(a, b, sub, in_tag));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 20) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 20", got); end
    n_checks++; if (last - first != 19) begin n_fail++; $display("FAIL b2b_throughput: got span %0d cycles expected 19", last - first); end
  endtask

  task automatic test_backpressure();
    int got = 0, sent = 0;
    logic [16:0] held;
    logic [3:0]  held_tag;
    logic [15:0] op_a, op_b;
    logic        op_s;
    logic [EW-1:0] e;
    exp_q.delete();
    held = '0; held_tag = '0;
    op_a = 16'($urandom_range(0, 65535)); op_b = 16'($urandom_range(0, 65535)); op_s = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 50 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 10);
      #1;
      if (cyc == 4) begin held = out; held_tag = out_tag; end
      if (cyc >= 4 && cyc <= 9) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", cyc, in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_c%0d: got %b expected 1", cyc, out_valid); end
        if (cyc > 4) begin
          n_checks++; if (out !== held) begin n_fail++; $display("FAIL bp_out_stable_c%0d: got %h expected %h", cyc, out, held); end
          n_checks++; if (out_tag !== held_tag) begin n_fail++; $display("FAIL bp_tag_stable_c%0d: got %h expected %h", cyc, out_tag, held_tag); end
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_unexpected: got out %h expected no output", out);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (out !== e[16:0]) begin n_fail++; $display("FAIL bp_out%0d: got %h expected %h", got, out, e[16:0]); end
          n_checks++; if (out_tag !== e[39:36]) begin n_fail++; $display("FAIL bp_tag%0d: got %h expected %h", got, out_tag, e[39:36]); end
          n_checks++; if (out_u !== e[33:17]) begin n_fail++; $display("FAIL bp_out_u%0d: got %h expected %h", got, out_u, e[33:17]); end
        end
        got++;
      end
      if (sent < 5) begin
        a = op_a; b = op_b; sub = op_s; in_tag = 4'(8 + sent); in_valid = 1'b1;
        #1;
        if (in_ready) begin
          exp_q.push_back(model(a, b, sub, in_tag));
          sent++;
          op_a = 16'($urandom_range(0, 65535)); op_b = 16'($urandom_range(0, 65535)); op_s = 1'($urandom_range(0, 1));
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL bp_count: got %0d results expected 5", got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      sub = 1'($urandom_range(0, 1)); in_tag = 4'(i + 1); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_full: got out_valid %b expected 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL rm_async_valid_u: got %b expected 0", out_valid_u); end
    n_checks++; if (out !== 17'h0) begin n_fail++; $display("FAIL rm_async_out: got %h expected 0", out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_leak: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; sub = 1'b0; in_tag = 4'd7; in_valid = 1'b1;
    for (int c = 1; c <= STAGES; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== (c == STAGES)) begin
        n_fail++; $display("FAIL rm_latency_c%0d: got out_valid %b expected %b", c, out_valid, (c == STAGES));
      end
    end
    n_checks++; if (out !== 17'h01235) begin n_fail++; $display("FAIL rm_out: got %h expected 01235", out); end
    n_checks++; if (out_tag !== 4'd7) begin n_fail++; $display("FAIL rm_tag: got %h expected 7", out_tag); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
